// File: rtl/iguana_pkg.sv
// iguana_pkg: pad-ring sizing and the safe values driven on output-only pads
// while the pad ring is still disabled after reset.
package iguana_pkg;
   localparam int SpihNumCs        = 2;
   localparam int SlinkNumLanes    = 4;
   localparam int HyperBusNumChips = 2;
   localparam int HyperBusDqWidth  = 8;
   localparam logic UartTxSafe      = 1'b1;
   localparam logic SpihSckSafe     = 1'b0;
   localparam logic SpihCsbSafe     = 1'b1;
   localparam logic HyperCsNSafe    = 1'b1;
   localparam logic HyperCkSafe     = 1'b0;
   localparam logic HyperCkNSafe    = 1'b1;
   localparam logic HyperResetNSafe = 1'b0;
   localparam logic SlinkClkOSafe   = 1'b0;
   localparam logic SlinkOSafe      = 1'b0;
endpackage

// File: rtl/iguana_pad_bidir.sv
// iguana_pad_bidir: one-bit tristate pad cell; o always reflects the pad level.
module iguana_pad_bidir (
   inout  wire  pad,
   input  logic i,
   input  logic oe,
   output logic o
);
   assign pad = oe ? i : 1'bz;
   assign o   = pad;
endmodule

// File: rtl/iguana_chip.sv
// iguana_chip: pad ring with reset-safe output values, gated tristates, a
// boot-strap capture register and a UART receive synchronizer.
module iguana_chip #(
   parameter int SpihNumCs        = iguana_pkg::SpihNumCs,
   parameter int SlinkNumLanes    = iguana_pkg::SlinkNumLanes,
   parameter int HyperBusNumChips = iguana_pkg::HyperBusNumChips
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   inout  wire  [1:0]                  boot_mode_io,
   inout  wire                         testmode_io,
   inout  wire                         rtc_io,
   inout  wire                         jtag_tck_io,
   inout  wire                         jtag_trst_n_io,
   inout  wire                         jtag_tms_io,
   inout  wire                         jtag_tdi_io,
   inout  wire                         jtag_tdo_io,
   inout  wire                         uart_rx_io,
   inout  wire                         uart_tx_io,
   inout  wire                         i2c_sda_io,
   inout  wire                         i2c_scl_io,
   inout  wire                         spih_sck_io,
   inout  wire  [SpihNumCs-1:0]        spih_csb_io,
   inout  wire  [3:0]                  spih_sd_io,
   inout  wire                         slink_clk_i_io,
   inout  wire                         slink_clk_o_io,
   inout  wire  [SlinkNumLanes-1:0]    slink_i_io,
   inout  wire  [SlinkNumLanes-1:0]    slink_o_io,
   inout  wire  [HyperBusNumChips-1:0] hyper_cs_n_io,
   inout  wire                         hyper_ck_io,
   inout  wire                         hyper_ck_n_io,
   inout  wire                         hyper_rwds_io,
   inout  wire                         hyper_reset_n_io,
   inout  wire  [7:0]                  hyper_dq_io,
   output logic [1:0]                  boot_mode_o,
   output logic                        testmode_o,
   output logic                        rtc_o,
   output logic                        jtag_tck_o,
   output logic                        jtag_trst_n_o,
   output logic                        jtag_tms_o,
   output logic                        jtag_tdi_o,
   input  logic                        jtag_tdo_i,
   input  logic                        jtag_tdo_oe,
   output logic                        jtag_tdo_o,
   output logic                        uart_rx_o,
   input  logic                        uart_tx_i,
   output logic                        uart_tx_o,
   input  logic                        i2c_sda_i,
   input  logic                        i2c_sda_oe,
   output logic                        i2c_sda_o,
   input  logic                        i2c_scl_i,
   input  logic                        i2c_scl_oe,
   output logic                        i2c_scl_o,
   input  logic                        spih_sck_i,
   output logic                        spih_sck_o,
   input  logic [SpihNumCs-1:0]        spih_csb_i,
   output logic [SpihNumCs-1:0]        spih_csb_o,
   input  logic [3:0]                  spih_sd_i,
   input  logic [3:0]                  spih_sd_oe,
   output logic [3:0]                  spih_sd_o,
   output logic                        slink_clk_i_o,
   input  logic                        slink_clk_o_i,
   output logic                        slink_clk_o_o,
   output logic [SlinkNumLanes-1:0]    slink_i_o,
   input  logic [SlinkNumLanes-1:0]    slink_o_i,
   output logic [SlinkNumLanes-1:0]    slink_o_o,
   input  logic [HyperBusNumChips-1:0] hyper_cs_n_i,
   output logic [HyperBusNumChips-1:0] hyper_cs_n_o,
   input  logic                        hyper_ck_i,
   output logic                        hyper_ck_o,
   output logic                        hyper_ck_n_o,
   input  logic                        hyper_rwds_i,
   input  logic                        hyper_rwds_oe,
   output logic                        hyper_rwds_o,
   input  logic                        hyper_reset_n_i,
   output logic                        hyper_reset_n_o,
   input  logic [7:0]                  hyper_dq_i,
   input  logic                        hyper_dq_oe,
   output logic [7:0]                  hyper_dq_o
);
   logic       pads_en_q, pads_en_d;
   logic       captured_q, captured_d;
   logic [1:0] boot_mode_q, boot_mode_d;
   logic [1:0] uart_rx_sync_q, uart_rx_sync_d;
   logic       unused_i2c;
   always_comb begin
      pads_en_d      = 1'b1;
      captured_d     = 1'b1;
      boot_mode_d    = captured_q ? boot_mode_q : boot_mode_io;
      uart_rx_sync_d = {uart_rx_sync_q[0], uart_rx_io};
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pads_en_q      <= 1'b0;
         captured_q     <= 1'b0;
         boot_mode_q    <= 2'b00;
         uart_rx_sync_q <= 2'b11;
      end else begin
         pads_en_q      <= pads_en_d;
         captured_q     <= captured_d;
         boot_mode_q    <= boot_mode_d;
         uart_rx_sync_q <= uart_rx_sync_d;
      end
   end
   assign boot_mode_o   = boot_mode_q;
   assign uart_rx_o     = uart_rx_sync_q[1];
   assign testmode_o    = testmode_io;
   assign rtc_o         = rtc_io;
   assign jtag_tck_o    = jtag_tck_io;
   assign jtag_trst_n_o = jtag_trst_n_io;
   assign jtag_tms_o    = jtag_tms_io;
   assign jtag_tdi_o    = jtag_tdi_io;
   assign slink_clk_i_o = slink_clk_i_io;
   assign slink_i_o     = slink_i_io;
   // Output-only pads: safe constants until the first clock after reset.
   assign uart_tx_io       = pads_en_q ? uart_tx_i       : iguana_pkg::UartTxSafe;
   assign spih_sck_io      = pads_en_q ? spih_sck_i      : iguana_pkg::SpihSckSafe;
   assign spih_csb_io      = pads_en_q ? spih_csb_i      : {SpihNumCs{iguana_pkg::SpihCsbSafe}};
   assign hyper_cs_n_io    = pads_en_q ? hyper_cs_n_i    : {HyperBusNumChips{iguana_pkg::HyperCsNSafe}};
   assign hyper_ck_io      = pads_en_q ? hyper_ck_i      : iguana_pkg::HyperCkSafe;
   assign hyper_ck_n_io    = pads_en_q ? ~hyper_ck_i     : iguana_pkg::HyperCkNSafe;
   assign hyper_reset_n_io = pads_en_q ? hyper_reset_n_i : iguana_pkg::HyperResetNSafe;
   assign slink_clk_o_io   = pads_en_q ? slink_clk_o_i   : iguana_pkg::SlinkClkOSafe;
   assign slink_o_io       = pads_en_q ? slink_o_i       : {SlinkNumLanes{iguana_pkg::SlinkOSafe}};
   assign uart_tx_o       = uart_tx_io;
   assign spih_sck_o      = spih_sck_io;
   assign spih_csb_o      = spih_csb_io;
   assign hyper_cs_n_o    = hyper_cs_n_io;
   assign hyper_ck_o      = hyper_ck_io;
   assign hyper_ck_n_o    = hyper_ck_n_io;
   assign hyper_reset_n_o = hyper_reset_n_io;
   assign slink_clk_o_o   = slink_clk_o_io;
   assign slink_o_o       = slink_o_io;
   iguana_pad_bidir u_jtag_tdo (.pad(jtag_tdo_io), .i(jtag_tdo_i), .oe(pads_en_q & jtag_tdo_oe), .o(jtag_tdo_o));
   iguana_pad_bidir u_hyper_rwds (.pad(hyper_rwds_io), .i(hyper_rwds_i), .oe(pads_en_q & hyper_rwds_oe), .o(hyper_rwds_o));
   // I2C is open-drain: only ever pulls low, the core value is irrelevant.
   iguana_pad_bidir u_i2c_sda (.pad(i2c_sda_io), .i(1'b0), .oe(pads_en_q & i2c_sda_oe), .o(i2c_sda_o));
   iguana_pad_bidir u_i2c_scl (.pad(i2c_scl_io), .i(1'b0), .oe(pads_en_q & i2c_scl_oe), .o(i2c_scl_o));
   assign unused_i2c = i2c_sda_i ^ i2c_scl_i;
   for (genvar g = 0; g < 4; g++) begin : g_spih_sd
      iguana_pad_bidir u_pad (.pad(spih_sd_io[g]), .i(spih_sd_i[g]), .oe(pads_en_q & spih_sd_oe[g]), .o(spih_sd_o[g]));
   end
   for (genvar g = 0; g < iguana_pkg::HyperBusDqWidth; g++) begin : g_hyper_dq
      iguana_pad_bidir u_pad (.pad(hyper_dq_io[g]), .i(hyper_dq_i[g]), .oe(pads_en_q & hyper_dq_oe), .o(hyper_dq_o[g]));
   end
endmodule

// File: tb/tb_iguana_chip.sv
// tb_iguana_chip: directed checks of reset-safe pads, tristate gating, boot
// strap capture, UART synchronizer latency and asynchronous reset.
module tb_iguana_chip;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   logic [1:0] boot_drv = 2'b10;
   logic       uart_rx_drv = 1'b1, testmode_drv = 1'b1;
   logic       dq_en = 1'b1, sd_en = 1'b0;
   logic [7:0] dq_drv = 8'h3C;
   logic [3:0] sd_drv = 4'h5;
   wire  [1:0] boot_mode_io;
   wire testmode_io, rtc_io, jtag_tck_io, jtag_trst_n_io, jtag_tms_io, jtag_tdi_io, jtag_tdo_io;
   wire uart_rx_io, uart_tx_io, i2c_sda_io, i2c_scl_io, spih_sck_io;
   wire [1:0] spih_csb_io;
   wire [3:0] spih_sd_io, slink_i_io, slink_o_io;
   wire slink_clk_i_io, slink_clk_o_io, hyper_ck_io, hyper_ck_n_io, hyper_rwds_io, hyper_reset_n_io;
   wire [1:0] hyper_cs_n_io;
   wire [7:0] hyper_dq_io;
   assign boot_mode_io   = boot_drv;
   assign testmode_io    = testmode_drv;
   assign rtc_io         = 1'b0;
   assign jtag_tck_io    = 1'b0;
   assign jtag_trst_n_io = 1'b1;
   assign jtag_tms_io    = 1'b0;
   assign jtag_tdi_io    = 1'b0;
   assign uart_rx_io     = uart_rx_drv;
   assign slink_clk_i_io = 1'b0;
   assign slink_i_io     = 4'h0;
   assign hyper_dq_io    = dq_en ? dq_drv : 8'hzz;
   assign spih_sd_io     = sd_en ? sd_drv : 4'hz;
   pullup (i2c_sda_io);
   pullup (i2c_scl_io);
   logic [1:0] boot_mode_o, spih_csb_i, spih_csb_o, hyper_cs_n_i, hyper_cs_n_o;
   logic testmode_o, rtc_o, jtag_tck_o, jtag_trst_n_o, jtag_tms_o, jtag_tdi_o, jtag_tdo_o, uart_rx_o, uart_tx_o;
   logic i2c_sda_o, i2c_scl_o, spih_sck_o, slink_clk_i_o, slink_clk_o_o, hyper_ck_o, hyper_ck_n_o;
   logic hyper_rwds_o, hyper_reset_n_o;
   logic [3:0] spih_sd_o, slink_i_o, slink_o_o;
   logic [7:0] hyper_dq_o;
   logic jtag_tdo_i = 1'b0, jtag_tdo_oe = 1'b0, uart_tx_i = 1'b0;
   logic i2c_sda_i = 1'b1, i2c_sda_oe = 1'b1, i2c_scl_i = 1'b1, i2c_scl_oe = 1'b0;
   logic spih_sck_i = 1'b1, slink_clk_o_i = 1'b1, hyper_ck_i = 1'b1;
   logic hyper_rwds_i = 1'b0, hyper_rwds_oe = 1'b0, hyper_reset_n_i = 1'b1, hyper_dq_oe = 1'b1;
   logic [3:0] spih_sd_i = 4'h0, spih_sd_oe = 4'h0, slink_o_i = 4'hF;
   logic [7:0] hyper_dq_i = 8'hA5;
   initial begin
      spih_csb_i   = 2'b00;
      hyper_cs_n_i = 2'b00;
   end
   iguana_chip dut (
      .clk_i(clk), .rst_i(rst),
      .boot_mode_io(boot_mode_io), .testmode_io(testmode_io), .rtc_io(rtc_io),
      .jtag_tck_io(jtag_tck_io), .jtag_trst_n_io(jtag_trst_n_io), .jtag_tms_io(jtag_tms_io),
      .jtag_tdi_io(jtag_tdi_io), .jtag_tdo_io(jtag_tdo_io),
      .uart_rx_io(uart_rx_io), .uart_tx_io(uart_tx_io), .i2c_sda_io(i2c_sda_io), .i2c_scl_io(i2c_scl_io),
      .spih_sck_io(spih_sck_io), .spih_csb_io(spih_csb_io), .spih_sd_io(spih_sd_io),
      .slink_clk_i_io(slink_clk_i_io), .slink_clk_o_io(slink_clk_o_io), .slink_i_io(slink_i_io),
      .slink_o_io(slink_o_io), .hyper_cs_n_io(hyper_cs_n_io), .hyper_ck_io(hyper_ck_io),
      .hyper_ck_n_io(hyper_ck_n_io), .hyper_rwds_io(hyper_rwds_io), .hyper_reset_n_io(hyper_reset_n_io),
      .hyper_dq_io(hyper_dq_io),
      .boot_mode_o(boot_mode_o), .testmode_o(testmode_o), .rtc_o(rtc_o),
      .jtag_tck_o(jtag_tck_o), .jtag_trst_n_o(jtag_trst_n_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o),
      .jtag_tdo_i(jtag_tdo_i), .jtag_tdo_oe(jtag_tdo_oe), .jtag_tdo_o(jtag_tdo_o),
      .uart_rx_o(uart_rx_o), .uart_tx_i(uart_tx_i), .uart_tx_o(uart_tx_o),
      .i2c_sda_i(i2c_sda_i), .i2c_sda_oe(i2c_sda_oe), .i2c_sda_o(i2c_sda_o),
      .i2c_scl_i(i2c_scl_i), .i2c_scl_oe(i2c_scl_oe), .i2c_scl_o(i2c_scl_o),
      .spih_sck_i(spih_sck_i), .spih_sck_o(spih_sck_o), .spih_csb_i(spih_csb_i), .spih_csb_o(spih_csb_o),
      .spih_sd_i(spih_sd_i), .spih_sd_oe(spih_sd_oe), .spih_sd_o(spih_sd_o),
      .slink_clk_i_o(slink_clk_i_o), .slink_clk_o_i(slink_clk_o_i), .slink_clk_o_o(slink_clk_o_o),
      .slink_i_o(slink_i_o), .slink_o_i(slink_o_i), .slink_o_o(slink_o_o),
      .hyper_cs_n_i(hyper_cs_n_i), .hyper_cs_n_o(hyper_cs_n_o), .hyper_ck_i(hyper_ck_i), .hyper_ck_o(hyper_ck_o),
      .hyper_ck_n_o(hyper_ck_n_o), .hyper_rwds_i(hyper_rwds_i), .hyper_rwds_oe(hyper_rwds_oe),
      .hyper_rwds_o(hyper_rwds_o), .hyper_reset_n_i(hyper_reset_n_i), .hyper_reset_n_o(hyper_reset_n_o),
      .hyper_dq_i(hyper_dq_i), .hyper_dq_oe(hyper_dq_oe), .hyper_dq_o(hyper_dq_o)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      #12;
      // In reset: a lone external driver wins only if the chip is high-Z.
      check("rst_dq_z", hyper_dq_io, 8'h3C);
      check("rst_uart_tx", uart_tx_io, 1'b1);
      check("rst_cs_n", hyper_cs_n_io, 2'b11);
      check("rst_ck_n", hyper_ck_n_io, 1'b1);
      check("rst_ck", hyper_ck_io, 1'b0);
      check("rst_reset_n", hyper_reset_n_io, 1'b0);
      check("rst_sck", spih_sck_io, 1'b0);
      check("rst_csb", spih_csb_io, 2'b11);
      check("rst_slink_clk", slink_clk_o_io, 1'b0);
      check("rst_slink_o", slink_o_io, 4'h0);
      check("rst_sda_z", i2c_sda_io, 1'b1);
      check("rst_boot", boot_mode_o, 2'b00);
      check("rst_uart_rx", uart_rx_o, 1'b1);
      check("rst_uart_tx_o", uart_tx_o, 1'b1);
      check("testmode", testmode_o, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("pre_edge_dq_z", hyper_dq_io, 8'h3C);
      check("pre_edge_boot", boot_mode_o, 2'b00);
      dq_en = 1'b0;
      @(negedge clk);
      check("en_dq", hyper_dq_io, 8'hA5);
      check("en_dq_o", hyper_dq_o, 8'hA5);
      check("en_uart_tx", uart_tx_io, 1'b0);
      check("en_ck_n", hyper_ck_n_io, 1'b0);
      check("en_cs_n", hyper_cs_n_io, 2'b00);
      check("en_slink_o", slink_o_io, 4'hF);
      check("boot_cap", boot_mode_o, 2'b10);
      check("sda_low", i2c_sda_io, 1'b0);
      check("sda_low_o", i2c_sda_o, 1'b0);
      check("scl_z", i2c_scl_io, 1'b1);
      hyper_dq_oe = 1'b0;
      dq_en = 1'b1;
      #1;
      check("dq_ext", hyper_dq_io, 8'h3C);
      check("dq_ext_o", hyper_dq_o, 8'h3C);
      i2c_sda_oe = 1'b0;
      #1;
      check("sda_pull", i2c_sda_io, 1'b1);
      check("sda_pull_o", i2c_sda_o, 1'b1);
      boot_drv = 2'b01;
      uart_tx_i = 1'b1;
      hyper_ck_i = 1'b0;
      slink_o_i = 4'h5;
      #1;
      check("follow_uart_tx", uart_tx_io, 1'b1);
      check("follow_ck_n", hyper_ck_n_io, 1'b1);
      check("follow_slink_o", slink_o_io, 4'h5);
      @(negedge clk);
      @(negedge clk);
      check("boot_hold", boot_mode_o, 2'b10);
      uart_rx_drv = 1'b0;
      @(negedge clk);
      check("rx_lat1", uart_rx_o, 1'b1);
      @(negedge clk);
      check("rx_lat2", uart_rx_o, 1'b0);
      sd_en = 1'b0;
      spih_sd_i = 4'hA;
      spih_sd_oe = 4'hF;
      #1;
      check("sd_drive", spih_sd_io, 4'hA);
      check("sd_drive_o", spih_sd_o, 4'hA);
      check("csb_follow", spih_csb_io, 2'b00);
      #1;
      rst = 1'b1;
      sd_en = 1'b1;
      #1;
      check("async_sd_z", spih_sd_io, 4'h5);
      check("async_csb", spih_csb_io, 2'b11);
      check("async_boot", boot_mode_o, 2'b00);
      check("async_rx", uart_rx_o, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reboot_cap", boot_mode_o, 2'b01);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
